// File: rtl/ay_sched.sv
// AY bus scheduler: CPU pass-through port plus queued register writes.
// Build option AY_SCHED_RESTORE_EN adds a RESTORE phase that rewrites the CPU's last address.
module ay_sched #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic       cpu_addr,
  input  logic [7:0] cpu_di,
  output logic [7:0] cpu_do,
  output logic       cpu_busy,
  input  logic       q_wr,
  input  logic [3:0] q_reg,
  input  logic [7:0] q_val,
  output logic       q_full,
  output logic       q_empty,
  output logic       q_ovf,
  output logic       ay_address,
  output logic [7:0] ay_data,
  output logic       ay_wren,
  output logic       ay_rden,
  input  logic [7:0] ay_q
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    CPU_OP,
    Q_ADDR,
    Q_DATA
`ifdef AY_SCHED_RESTORE_EN
    , RESTORE
`endif
  } state_t;

  state_t state, state_nx;

  logic       pend_addr;
  logic       pend_rd;
  logic [7:0] pend_di;
  logic       strobe;

  logic [3:0]            fifo_reg [DEPTH];
  logic [7:0]            fifo_val [DEPTH];
  logic [DEPTH_LOG2-1:0] wp, rp;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  push, pop;

  logic       hold_addr;
  logic [7:0] hold_data;
  logic       cpu_done;

`ifdef AY_SCHED_RESTORE_EN
  logic [7:0] shadow;
`endif

  assign strobe   = (cpu_wr | cpu_rd) & ~cpu_busy;
  assign q_full   = (cnt == FULL_CNT);
  assign q_empty  = (cnt == '0);
  assign pop      = ce && (state == Q_DATA);
  assign push     = q_wr && (!q_full || pop);
  assign cpu_done = ce && (state == CPU_OP);

  // Next phase: only advances on ce; CPU (pending or arriving) beats the queue.
  always_comb begin
    state_nx = state;
    if (ce) begin
      unique case (state)
        IDLE: begin
          if (cpu_busy || strobe) state_nx = CPU_OP;
          else if (!q_empty)      state_nx = Q_ADDR;
        end
        CPU_OP: state_nx = IDLE;
        Q_ADDR: state_nx = Q_DATA;
`ifdef AY_SCHED_RESTORE_EN
        Q_DATA:  state_nx = RESTORE;
        RESTORE: state_nx = IDLE;
`else
        Q_DATA:  state_nx = IDLE;
`endif
        default: state_nx = IDLE;
      endcase
    end
  end

  // Bus drive: phase values held until the next ce, strobes only on ce.
  always_comb begin
    ay_address = hold_addr;
    ay_data    = hold_data;
    ay_wren    = 1'b0;
    ay_rden    = 1'b0;
    unique case (state)
      CPU_OP: begin
        ay_address = pend_addr;
        ay_data    = pend_di;
        ay_wren    = ce & ~pend_rd;
        ay_rden    = ce & pend_rd;
      end
      Q_ADDR: begin
        ay_address = 1'b1;
        ay_data    = {4'b0, fifo_reg[rp]};
        ay_wren    = ce;
      end
      Q_DATA: begin
        ay_address = 1'b0;
        ay_data    = fifo_val[rp];
        ay_wren    = ce;
      end
`ifdef AY_SCHED_RESTORE_EN
      RESTORE: begin
        ay_address = 1'b1;
        ay_data    = shadow;
        ay_wren    = ce;
      end
`endif
      default: ;
    endcase
  end

  // Phase register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // CPU slot: latch one access, release it once issued on the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_busy  <= 1'b0;
      pend_addr <= 1'b0;
      pend_rd   <= 1'b0;
      pend_di   <= '0;
      cpu_do    <= '0;
    end else begin
      if (cpu_done) begin
        cpu_busy <= 1'b0;
        if (pend_rd) cpu_do <= ay_q;
      end else if (strobe) begin
        cpu_busy  <= 1'b1;
        pend_addr <= cpu_addr;
        pend_rd   <= cpu_rd;
        pend_di   <= cpu_di;
      end
    end
  end

  // Bus hold values and CPU address shadow, captured as each phase issues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_addr <= 1'b0;
      hold_data <= '0;
`ifdef AY_SCHED_RESTORE_EN
      shadow    <= '0;
`endif
    end else if (ce && state != IDLE) begin
      hold_addr <= ay_address;
      hold_data <= ay_data;
`ifdef AY_SCHED_RESTORE_EN
      if (state == CPU_OP && !pend_rd && pend_addr) shadow <= pend_di;
`endif
    end
  end

  // Queue storage; only occupied slots are read so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wp] <= q_reg;
      fifo_val[wp] <= q_val;
    end
  end

  // Queue pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      q_ovf <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
      if (q_wr && !push) q_ovf <= 1'b1;
    end
  end

endmodule
